// File: rtl/pulse_channel_pkg.sv
// Shared types for the pulse channel: FSM states, duty codes and the duty threshold table.
package pulse_channel_pkg;

    localparam int unsigned DUTY_IDX_W = 3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PLAY = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        DUTY_12 = 2'b00,
        DUTY_25 = 2'b01,
        DUTY_50 = 2'b10,
        DUTY_75 = 2'b11
    } duty_t;

    // Number of high eighths of the waveform for each duty code.
    function automatic logic [DUTY_IDX_W-1:0] duty_threshold(input duty_t duty);
        case (duty)
            DUTY_12: return 3'd1;
            DUTY_25: return 3'd2;
            DUTY_50: return 3'd4;
            default: return 3'd6;
        endcase
    endfunction

    function automatic logic duty_high(input logic [DUTY_IDX_W-1:0] top3, input duty_t duty);
        return top3 < duty_threshold(duty);
    endfunction

endpackage

// File: rtl/pulse_channel_envelope.sv
// Decaying volume envelope: level steps down every 'period' ticks, optionally looping.
module pulse_channel_envelope
    import pulse_channel_pkg::*;
#(
    parameter int unsigned OUT_WIDTH = 9,
    parameter int unsigned ENV_PER_W = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 trigger,
    input  logic                 step,
    input  logic [OUT_WIDTH-1:0] volume,
    input  logic [ENV_PER_W-1:0] period,
    input  logic                 loop,
    output logic [OUT_WIDTH-1:0] level,
    output logic                 done_c
);

    logic [ENV_PER_W-1:0] env_cnt;
    logic [ENV_PER_W-1:0] env_cnt_nxt;
    logic [ENV_PER_W-1:0] period_q;
    logic                 loop_q;
    logic [OUT_WIDTH-1:0] level_nxt;

    // Without loop the note ends on the step that takes the level to zero.
    always_comb begin
        level_nxt   = level;
        env_cnt_nxt = env_cnt;
        done_c      = 1'b0;
        if (trigger) begin
            level_nxt   = volume;
            env_cnt_nxt = period;
        end else if (step && (period_q != '0)) begin
            if (env_cnt <= ENV_PER_W'(1)) begin
                env_cnt_nxt = period_q;
                if (level == '0) begin
                    if (loop_q) begin
                        level_nxt = volume;
                    end else begin
                        done_c = 1'b1;
                    end
                end else begin
                    level_nxt = level - OUT_WIDTH'(1);
                    done_c    = !loop_q && (level == OUT_WIDTH'(1));
                end
            end else begin
                env_cnt_nxt = env_cnt - ENV_PER_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level    <= '0;
            env_cnt  <= '0;
            period_q <= '0;
            loop_q   <= 1'b0;
        end else begin
            level   <= level_nxt;
            env_cnt <= env_cnt_nxt;
            if (trigger) begin
                period_q <= period;
                loop_q   <= loop;
            end
        end
    end

endmodule

// File: rtl/pulse_channel.sv
// Pulse-wave voice: phase accumulator, 4 duty cycles, envelope and length counter.
// Optional frequency sweep is built when PULSE_CHANNEL_SWEEP_EN is defined.
module pulse_channel
    import pulse_channel_pkg::*;
#(
    parameter int unsigned PHASE_WIDTH = 32,
    parameter int unsigned OUT_WIDTH   = 9,
    parameter int unsigned ENV_PER_W   = 4,
    parameter int unsigned LEN_WIDTH   = 8
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_tick_stb,
    input  logic                   i_trigger,
    input  logic [PHASE_WIDTH-1:0] i_phase_delta,
    input  logic                   i_phase_delta_vld,
    input  logic [1:0]             i_duty,
    input  logic [OUT_WIDTH-1:0]   i_volume,
    input  logic [ENV_PER_W-1:0]   i_env_period,
    input  logic                   i_env_loop,
    input  logic [LEN_WIDTH-1:0]   i_len,
    input  logic                   i_len_en,
`ifdef PULSE_CHANNEL_SWEEP_EN
    input  logic                   i_sweep_en,
    input  logic                   i_sweep_neg,
    input  logic [4:0]             i_sweep_shift,
    input  logic [2:0]             i_sweep_period,
`endif
    output logic [OUT_WIDTH-1:0]   o_output,
    output logic                   o_frame_pulse,
    output logic                   o_active
);

    state_t                 state;
    state_t                 state_nxt;
    logic [PHASE_WIDTH-1:0] phase;
    logic [PHASE_WIDTH-1:0] delta;
    logic [PHASE_WIDTH-1:0] delta_nxt;
    logic [LEN_WIDTH-1:0]   len_cnt;
    logic [LEN_WIDTH-1:0]   len_cnt_nxt;
    duty_t                  duty_q;
    logic                   len_en_q;
    logic [OUT_WIDTH-1:0]   level;
    logic [OUT_WIDTH-1:0]   sample_c;
    logic                   tick_play_c;
    logic                   restart_c;
    logic                   env_done_c;
    logic                   len_expire_c;
    logic                   sweep_ovf_c;

    // A trigger swallows any tick in the same cycle.
    assign tick_play_c = i_tick_stb && (state == ST_PLAY) && !i_trigger;
    assign restart_c   = i_trigger && !(i_len_en && (i_len == '0));

    pulse_channel_envelope #(
        .OUT_WIDTH (OUT_WIDTH),
        .ENV_PER_W (ENV_PER_W)
    ) u_envelope (
        .clk     (i_clk),
        .rst_n   (i_rst_n),
        .trigger (i_trigger),
        .step    (tick_play_c),
        .volume  (i_volume),
        .period  (i_env_period),
        .loop    (i_env_loop),
        .level   (level),
        .done_c  (env_done_c)
    );

    // Length counter: expiry is the 1 -> 0 transition on a tick.
    always_comb begin
        len_cnt_nxt  = len_cnt;
        len_expire_c = 1'b0;
        if (i_trigger) begin
            len_cnt_nxt = i_len;
        end else if (tick_play_c && len_en_q && (len_cnt != '0)) begin
            len_cnt_nxt  = len_cnt - LEN_WIDTH'(1);
            len_expire_c = (len_cnt == LEN_WIDTH'(1));
        end
    end

`ifdef PULSE_CHANNEL_SWEEP_EN
    logic [2:0]             sweep_cnt;
    logic [2:0]             sweep_cnt_nxt;
    logic [PHASE_WIDTH-1:0] sweep_step_c;
    logic [PHASE_WIDTH:0]   sweep_sum_c;
    logic                   sweep_apply_c;

    // Sweep adjusts delta by a shifted copy of itself; an upward carry mutes the note.
    always_comb begin
        sweep_cnt_nxt = sweep_cnt;
        sweep_apply_c = 1'b0;
        sweep_ovf_c   = 1'b0;
        delta_nxt     = delta;
        sweep_step_c  = delta >> i_sweep_shift;
        sweep_sum_c   = {1'b0, delta} + {1'b0, sweep_step_c};
        if (i_trigger) begin
            sweep_cnt_nxt = i_sweep_period;
        end else if (tick_play_c && i_sweep_en) begin
            if (sweep_cnt <= 3'd1) begin
                sweep_cnt_nxt = i_sweep_period;
                sweep_apply_c = (i_sweep_shift != '0);
            end else begin
                sweep_cnt_nxt = sweep_cnt - 3'd1;
            end
        end
        sweep_ovf_c = sweep_apply_c && !i_sweep_neg && sweep_sum_c[PHASE_WIDTH];
        if (i_phase_delta_vld) begin
            delta_nxt = i_phase_delta;
        end else if (sweep_apply_c && !sweep_ovf_c) begin
            delta_nxt = i_sweep_neg ? (delta - sweep_step_c) : sweep_sum_c[PHASE_WIDTH-1:0];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sweep_cnt <= '0;
        end else begin
            sweep_cnt <= sweep_cnt_nxt;
        end
    end
`else
    assign sweep_ovf_c = 1'b0;

    always_comb begin
        delta_nxt = i_phase_delta_vld ? i_phase_delta : delta;
    end
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and sample level; a trigger always wins over end-of-note events.
    always_comb begin
        state_nxt = state;
        sample_c  = '0;
        case (state)
            ST_IDLE: begin
                if (restart_c) begin
                    state_nxt = ST_PLAY;
                end
            end
            ST_PLAY: begin
                if (duty_high(phase[PHASE_WIDTH-1 -: DUTY_IDX_W], duty_q)) begin
                    sample_c = level;
                end
                if (i_trigger) begin
                    state_nxt = restart_c ? ST_PLAY : ST_IDLE;
                end else if (len_expire_c || env_done_c || sweep_ovf_c) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            phase    <= '0;
            delta    <= '0;
            len_cnt  <= '0;
            duty_q   <= DUTY_12;
            len_en_q <= 1'b0;
            o_output <= '0;
        end else begin
            phase    <= i_trigger ? '0 : (phase + delta);
            delta    <= delta_nxt;
            len_cnt  <= len_cnt_nxt;
            o_output <= sample_c;
            if (i_trigger) begin
                duty_q   <= duty_t'(i_duty);
                len_en_q <= i_len_en;
            end
        end
    end

    assign o_frame_pulse = phase[PHASE_WIDTH-1];
    assign o_active      = (state == ST_PLAY);

endmodule

// File: tb/tb_pulse_channel.sv
// Scoreboard bench for pulse_channel; sweep scenario built with PULSE_CHANNEL_SWEEP_EN.
module tb_pulse_channel;

    logic        i_clk;
    logic        i_rst_n;
    logic        i_tick_stb;
    logic        i_trigger;
    logic [31:0] i_phase_delta;
    logic        i_phase_delta_vld;
    logic [1:0]  i_duty;
    logic [8:0]  i_volume;
    logic [3:0]  i_env_period;
    logic        i_env_loop;
    logic [7:0]  i_len;
    logic        i_len_en;
`ifdef PULSE_CHANNEL_SWEEP_EN
    logic        i_sweep_en;
    logic        i_sweep_neg;
    logic [4:0]  i_sweep_shift;
    logic [2:0]  i_sweep_period;
`endif
    logic [8:0]  o_output;
    logic        o_frame_pulse;
    logic        o_active;

    int n_cmp;
    int n_bad;
    logic [8:0] exp_out_q[$];
    logic       exp_bit_q[$];

    pulse_channel dut (
        .i_clk             (i_clk),
        .i_rst_n           (i_rst_n),
        .i_tick_stb        (i_tick_stb),
        .i_trigger         (i_trigger),
        .i_phase_delta     (i_phase_delta),
        .i_phase_delta_vld (i_phase_delta_vld),
        .i_duty            (i_duty),
        .i_volume          (i_volume),
        .i_env_period      (i_env_period),
        .i_env_loop        (i_env_loop),
        .i_len             (i_len),
        .i_len_en          (i_len_en),
`ifdef PULSE_CHANNEL_SWEEP_EN
        .i_sweep_en        (i_sweep_en),
        .i_sweep_neg       (i_sweep_neg),
        .i_sweep_shift     (i_sweep_shift),
        .i_sweep_period    (i_sweep_period),
`endif
        .o_output          (o_output),
        .o_frame_pulse     (o_frame_pulse),
        .o_active          (o_active)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    function automatic int thr_of(input logic [1:0] d);
        case (d)
            2'd0:    return 1;
            2'd1:    return 2;
            2'd2:    return 4;
            default: return 6;
        endcase
    endfunction

    function automatic int highs_per_16(input logic [1:0] d);
        case (d)
            2'd0:    return 2;
            2'd1:    return 4;
            2'd2:    return 8;
            default: return 12;
        endcase
    endfunction

    function automatic logic [8:0] env_level(input int t, input logic loop);
        if (t < 2) return 9'd3;
        if (t < 4) return 9'd2;
        if (t < 6) return 9'd1;
        if (loop && t >= 8) return 9'd3;
        return 9'd0;
    endfunction

    task automatic trigger_note(input logic [1:0] duty, input logic [8:0] vol, input logic [3:0] per,
                                input logic loop, input logic [7:0] len, input logic len_en,
                                input logic [31:0] delta, input logic dvld);
        i_duty            = duty;
        i_volume          = vol;
        i_env_period      = per;
        i_env_loop        = loop;
        i_len             = len;
        i_len_en          = len_en;
        i_phase_delta     = delta;
        i_phase_delta_vld = dvld;
        i_trigger         = 1'b1;
        step();
        i_trigger         = 1'b0;
        i_phase_delta_vld = 1'b0;
    endtask

    task automatic tick();
        i_tick_stb = 1'b1;
        step();
        i_tick_stb = 1'b0;
    endtask

    task automatic test_reset();
        logic [8:0] eo;
        exp_out_q.push_back(9'd0);
        repeat (3) step();
        eo = exp_out_q.pop_front();
        n_cmp++;
        if (o_output !== eo) begin n_bad++; $display("FAIL reset_output got %h want %h", o_output, eo); end
        n_cmp++;
        if (o_active !== 1'b0) begin n_bad++; $display("FAIL reset_active got %b want 0", o_active); end
        n_cmp++;
        if (o_frame_pulse !== 1'b0) begin n_bad++; $display("FAIL reset_frame got %b want 0", o_frame_pulse); end
    endtask

    task automatic test_pattern(input logic [1:0] duty);
        int         highs;
        logic [8:0] eo;
        logic       ef;
        trigger_note(duty, 9'h1FF, 4'd0, 1'b0, 8'd0, 1'b0, 32'h1000_0000, 1'b1);
        n_cmp++;
        if (o_active !== 1'b1) begin n_bad++; $display("FAIL pattern_active duty=%0d got %b want 1", duty, o_active); end
        for (int k = 1; k <= 32; k++) begin
            exp_out_q.push_back((((k - 1) % 16) / 2 < thr_of(duty)) ? 9'h1FF : 9'h000);
            exp_bit_q.push_back((k % 16) >= 8);
        end
        highs = 0;
        for (int k = 1; k <= 32; k++) begin
            step();
            eo = exp_out_q.pop_front();
            ef = exp_bit_q.pop_front();
            n_cmp++;
            if (o_output !== eo) begin n_bad++; $display("FAIL pattern_out duty=%0d k=%0d got %h want %h", duty, k, o_output, eo); end
            n_cmp++;
            if (o_frame_pulse !== ef) begin n_bad++; $display("FAIL pattern_frame duty=%0d k=%0d got %b want %b", duty, k, o_frame_pulse, ef); end
            if (o_output == 9'h1FF) highs++;
        end
        n_cmp++;
        if (highs !== 2 * highs_per_16(duty)) begin
            n_bad++; $display("FAIL pattern_highs duty=%0d got %0d want %0d", duty, highs, 2 * highs_per_16(duty));
        end
    endtask

    task automatic test_envelope(input logic loop);
        logic [8:0] eo;
        logic       ea;
        trigger_note(2'd3, 9'd3, 4'd2, loop, 8'd0, 1'b0, 32'd0, 1'b1);
        exp_out_q.push_back(9'd3);
        step();
        eo = exp_out_q.pop_front();
        n_cmp++;
        if (o_output !== eo) begin n_bad++; $display("FAIL env_start loop=%b got %h want %h", loop, o_output, eo); end
        for (int t = 1; t <= 8; t++) begin
            exp_out_q.push_back(env_level(t, loop));
            exp_bit_q.push_back(loop || (t < 6));
            tick();
            repeat (99) step();
            eo = exp_out_q.pop_front();
            ea = exp_bit_q.pop_front();
            n_cmp++;
            if (o_output !== eo) begin n_bad++; $display("FAIL env_level loop=%b tick=%0d got %h want %h", loop, t, o_output, eo); end
            n_cmp++;
            if (o_active !== ea) begin n_bad++; $display("FAIL env_active loop=%b tick=%0d got %b want %b", loop, t, o_active, ea); end
        end
    endtask

    task automatic test_length();
        logic ea;
        trigger_note(2'd3, 9'h1FF, 4'd0, 1'b0, 8'd5, 1'b1, 32'd0, 1'b1);
        for (int t = 1; t <= 5; t++) begin
            exp_bit_q.push_back(t < 5);
            tick();
            ea = exp_bit_q.pop_front();
            n_cmp++;
            if (o_active !== ea) begin n_bad++; $display("FAIL len_active tick=%0d got %b want %b", t, o_active, ea); end
            repeat (9) step();
        end
        n_cmp++;
        if (o_output !== 9'd0) begin n_bad++; $display("FAIL len_silent got %h want 000", o_output); end
        // Restart on a tick cycle with one tick left on the old note.
        trigger_note(2'd3, 9'h1FF, 4'd0, 1'b0, 8'd3, 1'b1, 32'd0, 1'b1);
        tick(); repeat (4) step();
        tick(); repeat (4) step();
        i_tick_stb = 1'b1;
        trigger_note(2'd3, 9'h1FF, 4'd0, 1'b0, 8'd2, 1'b1, 32'd0, 1'b1);
        i_tick_stb = 1'b0;
        n_cmp++;
        if (o_active !== 1'b1) begin n_bad++; $display("FAIL len_retrig_active got %b want 1", o_active); end
        for (int t = 1; t <= 2; t++) begin
            exp_bit_q.push_back(t < 2);
            repeat (4) step();
            tick();
            ea = exp_bit_q.pop_front();
            n_cmp++;
            if (o_active !== ea) begin n_bad++; $display("FAIL len_retrig tick=%0d got %b want %b", t, o_active, ea); end
        end
        trigger_note(2'd3, 9'h1FF, 4'd0, 1'b0, 8'd0, 1'b1, 32'd0, 1'b1);
        n_cmp++;
        if (o_active !== 1'b0) begin n_bad++; $display("FAIL len_zero_active got %b want 0", o_active); end
        step();
        n_cmp++;
        if (o_output !== 9'd0) begin n_bad++; $display("FAIL len_zero_output got %h want 000", o_output); end
    endtask

    task automatic test_back_to_back();
        logic [8:0] eo;
        trigger_note(2'd3, 9'h0AA, 4'd0, 1'b0, 8'd0, 1'b0, 32'd0, 1'b1);
        exp_out_q.push_back(9'h0AA);
        trigger_note(2'd3, 9'h155, 4'd0, 1'b0, 8'd0, 1'b0, 32'd0, 1'b0);
        exp_out_q.push_back(9'h155);
        eo = exp_out_q.pop_front();
        n_cmp++;
        if (o_output !== eo) begin n_bad++; $display("FAIL b2b_first got %h want %h", o_output, eo); end
        step();
        eo = exp_out_q.pop_front();
        n_cmp++;
        if (o_output !== eo) begin n_bad++; $display("FAIL b2b_second got %h want %h", o_output, eo); end
    endtask

    task automatic test_reset_mid_note();
        trigger_note(2'd3, 9'h1FF, 4'd0, 1'b0, 8'd0, 1'b0, 32'h1000_0000, 1'b1);
        repeat (4) step();
        n_cmp++;
        if (o_output !== 9'h1FF) begin n_bad++; $display("FAIL midrst_pre got %h want 1ff", o_output); end
        #2;
        i_rst_n = 1'b0;
        #1;
        n_cmp++;
        if (o_output !== 9'd0) begin n_bad++; $display("FAIL midrst_output got %h want 000", o_output); end
        n_cmp++;
        if (o_active !== 1'b0) begin n_bad++; $display("FAIL midrst_active got %b want 0", o_active); end
        n_cmp++;
        if (o_frame_pulse !== 1'b0) begin n_bad++; $display("FAIL midrst_frame got %b want 0", o_frame_pulse); end
        step();
        i_rst_n = 1'b1;
        step();
        n_cmp++;
        if (o_output !== 9'd0) begin n_bad++; $display("FAIL midrst_release got %h want 000", o_output); end
        test_pattern(2'd3);
    endtask

`ifdef PULSE_CHANNEL_SWEEP_EN
    task automatic test_sweep();
        logic ea;
        logic ef;
        i_sweep_en     = 1'b1;
        i_sweep_neg    = 1'b0;
        i_sweep_shift  = 5'd1;
        i_sweep_period = 3'd1;
        trigger_note(2'd3, 9'h1FF, 4'd0, 1'b0, 8'd0, 1'b0, 32'h4000_0000, 1'b1);
        for (int t = 1; t <= 4; t++) begin
            exp_bit_q.push_back(t < 4);
            tick();
            repeat (3) step();
            ea = exp_bit_q.pop_front();
            n_cmp++;
            if (o_active !== ea) begin n_bad++; $display("FAIL sweep_add tick=%0d got %b want %b", t, o_active, ea); end
        end
        i_sweep_neg = 1'b1;
        trigger_note(2'd3, 9'h1FF, 4'd0, 1'b0, 8'd0, 1'b0, 32'h4000_0000, 1'b1);
        tick();
        i_sweep_en = 1'b0;
        trigger_note(2'd3, 9'h1FF, 4'd0, 1'b0, 8'd0, 1'b0, 32'd0, 1'b0);
        for (int k = 1; k <= 16; k++) exp_bit_q.push_back((k % 8) >= 4);
        for (int k = 1; k <= 16; k++) begin
            step();
            ef = exp_bit_q.pop_front();
            n_cmp++;
            if (o_frame_pulse !== ef) begin n_bad++; $display("FAIL sweep_neg k=%0d got %b want %b", k, o_frame_pulse, ef); end
        end
    endtask
`endif

    initial begin
        n_cmp             = 0;
        n_bad             = 0;
        i_rst_n           = 1'b0;
        i_tick_stb        = 1'b0;
        i_trigger         = 1'b0;
        i_phase_delta     = 32'd0;
        i_phase_delta_vld = 1'b0;
        i_duty            = 2'd0;
        i_volume          = 9'd0;
        i_env_period      = 4'd0;
        i_env_loop        = 1'b0;
        i_len             = 8'd0;
        i_len_en          = 1'b0;
`ifdef PULSE_CHANNEL_SWEEP_EN
        i_sweep_en        = 1'b0;
        i_sweep_neg       = 1'b0;
        i_sweep_shift     = 5'd0;
        i_sweep_period    = 3'd0;
`endif
        test_reset();
        i_rst_n = 1'b1;
        step();
        test_pattern(2'd3);
        test_pattern(2'd0);
        test_pattern(2'd1);
        test_pattern(2'd2);
        test_envelope(1'b0);
        test_envelope(1'b1);
        test_length();
        test_back_to_back();
        test_reset_mid_note();
`ifdef PULSE_CHANNEL_SWEEP_EN
        test_sweep();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
